// File: rtl/spike_loader_wbm.sv
// Wishbone initiator that writes one 256-bit spike vector into a core's axon
// spike memory as NUM_WORDS single-word writes, with per-word ack timeout.
module spike_loader_wbm #(
    parameter logic [31:0] IMEM_BASE_0    = 32'h80000000,
    parameter logic [31:0] IMEM_BASE_1    = 32'h80010000,
    parameter int          NUM_WORDS      = 8,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_core_i,
    input  logic [255:0] req_spikes_i,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic         wbm_ack_i,
    output logic [1:0]   core_en_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, STROBE, GAP, FINISH, ABORT} state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  tcnt;
    logic [255:0]   vec;
    logic           core;
    logic [IW-1:0]  nidx;

    assign nidx = idx + IW'(1);

    // Word 0 sits in the top 32 bits of the vector.
    function automatic logic [31:0] word_at(input logic [255:0] v, input logic [IW-1:0] i);
        return v[(NUM_WORDS - 1 - int'(i)) * 32 +: 32];
    endfunction

    function automatic logic [31:0] base_of(input logic c);
        return c ? IMEM_BASE_1 : IMEM_BASE_0;
    endfunction

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            idx         <= '0;
            tcnt        <= '0;
            vec         <= '0;
            core        <= 1'b0;
            req_ready_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0;
            wbm_dat_o   <= 32'h0;
            core_en_o   <= 2'b00;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        vec         <= req_spikes_i;
                        core        <= req_core_i;
                        idx         <= '0;
                        tcnt        <= '0;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        core_en_o   <= req_core_i ? 2'b10 : 2'b01;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= 1'b1;
                        wbm_sel_o   <= 4'hF;
                        wbm_adr_o   <= base_of(req_core_i);
                        wbm_dat_o   <= word_at(req_spikes_i, '0);
                        state       <= STROBE;
                    end
                end
                STROBE: begin
                    // An ack on the last allowed cycle takes priority over the timeout.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        if (idx == IW'(NUM_WORDS - 1)) begin
                            done_o <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            state  <= GAP;
                        end
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        err_o     <= 1'b1;
                        state     <= ABORT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    idx       <= nidx;
                    tcnt      <= '0;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= base_of(core) + 32'({nidx, 2'b00});
                    wbm_dat_o <= word_at(vec, nidx);
                    state     <= STROBE;
                end
                FINISH, ABORT: begin
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    core_en_o   <= 2'b00;
                    wbm_adr_o   <= 32'h0;
                    wbm_dat_o   <= 32'h0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_loader_wbm.sv
// Directed bench for spike_loader_wbm with a registered-ack Wishbone slave model
// that can insert wait states on one word or never ack one word.
module tb_spike_loader_wbm;
    logic         clk, rst_n;
    logic         req_valid, req_ready, req_core;
    logic [255:0] req_spikes;
    logic         cyc, stb, we, ack;
    logic [3:0]   sel;
    logic [31:0]  adr, dat;
    logic [1:0]   core_en;
    logic         busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    spike_loader_wbm dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_core_i(req_core),
        .req_spikes_i(req_spikes),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack),
        .core_en_o(core_en), .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: registered ack, optional wait states / missing ack on one word.
    int          noack_word = -1;
    int          wait_word  = -1;
    int          wait_n     = 0;
    int          wcnt;
    logic [31:0] mem [2][8];
    logic [31:0] wl_adr [512];
    logic [31:0] wl_dat [512];
    logic [1:0]  wl_en  [512];
    logic [4:0]  wl_attr[512];
    int          wl_n = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            wcnt <= 0;
        end else if (cyc && stb && !ack) begin
            if (int'(adr[4:2]) == noack_word) begin
                ack <= 1'b0;
            end else if (int'(adr[4:2]) == wait_word && wcnt < wait_n) begin
                wcnt <= wcnt + 1;
            end else begin
                ack                     <= 1'b1;
                wcnt                    <= 0;
                mem[adr[16]][adr[4:2]]  <= dat;
                wl_adr[wl_n]            <= adr;
                wl_dat[wl_n]            <= dat;
                wl_en[wl_n]             <= core_en;
                wl_attr[wl_n]           <= {we, sel};
                wl_n                    <= wl_n + 1;
            end
        end else begin
            ack  <= 1'b0;
            wcnt <= 0;
        end
    end

    int   stb2_cnt  = 0;
    logic both_seen = 1'b0;
    always @(negedge clk) begin
        if (stb && adr[4:2] == 3'd2) stb2_cnt++;
        if (core_en == 2'b11) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] mem_vec(input int c);
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], mem[c][i]};
        return v;
    endfunction

    function automatic int count_writes(input int from, input logic [31:0] a);
        int n = 0;
        for (int i = from; i < wl_n; i++) if (wl_adr[i] == a) n++;
        return n;
    endfunction

    // Cycle 0 is the accept cycle; cyc_n is the cycle in which done or err is seen.
    task automatic xfer(input logic c, input logic [255:0] v,
                        output int cyc_n, output logic got_done, output logic got_err);
        int guard = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_core = c; req_spikes = v;
        while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        req_valid = 1'b0;
        cyc_n = 1;
        while (guard < 400) begin
            if (done) begin got_done = 1'b1; break; end
            if (err)  begin got_err  = 1'b1; break; end
            @(negedge clk);
            cyc_n++;
            guard++;
        end
        if (!got_done && !got_err) chk("xfer_bound", 1'b0, 1'b1);
    endtask

    logic [255:0] va, vb, vr;
    int           cn, snap, s2, guard;
    logic         gd, ge;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_core = 1'b0; req_spikes = '0;
        for (int i = 0; i < 8; i++) va = {va[223:0], 32'hA0000000 + 32'(i)};

        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_bus",   {cyc, stb, we, sel, adr, dat}, '0);
        chk("rst_stat",  {core_en, busy, done, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Core 0, 1-cycle-ack slave.
        snap = wl_n;
        xfer(1'b0, va, cn, gd, ge);
        chk("c0_done_cyc", 32'(cn), 32'd24);
        chk("c0_flags", {gd, ge}, 2'b10);
        chk("c0_nwr", 32'(wl_n - snap), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("c0_adr",  wl_adr[snap+i], 32'h80000000 + 32'(4*i));
            chk("c0_dat",  wl_dat[snap+i], 32'hA0000000 + 32'(i));
            chk("c0_en",   wl_en[snap+i], 2'b01);
            chk("c0_attr", wl_attr[snap+i], 5'h1F);
        end
        @(negedge clk);
        chk("c0_idle", {req_ready, busy, core_en, cyc}, {1'b1, 1'b0, 2'b00, 1'b0});

        // Core 1, readback of full vector.
        snap = wl_n;
        xfer(1'b1, va, cn, gd, ge);
        chk("c1_done_cyc", 32'(cn), 32'd24);
        for (int i = 0; i < 8; i++) begin
            chk("c1_adr", wl_adr[snap+i], 32'h80010000 + 32'(4*i));
            chk("c1_en",  wl_en[snap+i], 2'b10);
        end
        chk("c1_readback", mem_vec(1), va);

        // Word 3 acked after 5 wait states.
        wait_word = 3; wait_n = 5;
        snap = wl_n;
        xfer(1'b0, ~va, cn, gd, ge);
        chk("ws_done_cyc", 32'(cn), 32'd29);
        chk("ws_flags", {gd, ge}, 2'b10);
        for (int i = 0; i < 8; i++)
            chk("ws_once", 32'(count_writes(snap, 32'h80000000 + 32'(4*i))), 32'd1);
        chk("ws_readback", mem_vec(0), ~va);

        // Ack on the 16th strobe cycle still wins; one cycle later times out.
        wait_n = 14;
        xfer(1'b0, va, cn, gd, ge);
        chk("edge_ok_cyc", 32'(cn), 32'd38);
        chk("edge_ok_flags", {gd, ge}, 2'b10);
        wait_n = 15;
        xfer(1'b0, va, cn, gd, ge);
        chk("edge_to_cyc", 32'(cn), 32'd26);
        chk("edge_to_flags", {gd, ge}, 2'b01);
        wait_word = -1; wait_n = 0;

        // Word 2 never acked.
        noack_word = 2;
        snap = wl_n; s2 = stb2_cnt;
        xfer(1'b0, va, cn, gd, ge);
        chk("to_err_cyc", 32'(cn), 32'd23);
        chk("to_flags", {gd, ge}, 2'b01);
        chk("to_bus_down", {cyc, stb}, 2'b00);
        chk("to_stb_cycles", 32'(stb2_cnt - s2), 32'd16);
        chk("to_nwr", 32'(wl_n - snap), 32'd2);
        @(negedge clk);
        chk("to_ready", {req_ready, err, done}, 3'b100);
        noack_word = -1;

        // Reset asserted during word 4.
        @(negedge clk);
        req_valid = 1'b1; req_core = 1'b1; req_spikes = va;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!(stb && adr[4:2] == 3'd4) && guard < 100) begin @(negedge clk); guard++; end
        chk("rw_reach_w4", {stb, adr[4:2]}, {1'b1, 3'd4});
        rst_n = 1'b0;
        #1;
        chk("rw_ready", req_ready, 1'b1);
        chk("rw_bus",   {cyc, stb, we, sel, adr, dat}, '0);
        chk("rw_stat",  {core_en, busy, done, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        snap = wl_n;
        xfer(1'b1, ~va, cn, gd, ge);
        chk("rw_restart_adr", wl_adr[snap], 32'h80010000);
        chk("rw_restart_cyc", 32'(cn), 32'd24);

        // Valid held with changing data while busy.
        for (int i = 0; i < 8; i++) vb = {vb[223:0], 32'h5A5A0000 + 32'(i * 3)};
        snap = wl_n;
        @(negedge clk);
        req_valid = 1'b1; req_core = 1'b0; req_spikes = va;
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
        cn = 0;
        guard = 0;
        do begin
            @(negedge clk);
            cn++; guard++;
            for (int i = 0; i < 8; i++) vr = {vr[223:0], $urandom};
            req_spikes = vr;
            req_core   = ~req_core;
        end while (!done && guard < 200);
        chk("hold_done_cyc", 32'(cn), 32'd24);
        chk("hold_first_vec", mem_vec(0), va);
        req_spikes = vb; req_core = 1'b1;
        @(negedge clk);
        chk("hold_ready_after_done", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_second_en", {busy, core_en}, {1'b1, 2'b10});
        guard = 0;
        while (!done && guard < 200) begin @(negedge clk); guard++; end
        chk("hold_second_done", done, 1'b1);
        chk("hold_second_vec", mem_vec(1), vb);
        chk("hold_nwr", 32'(wl_n - snap), 32'd16);

        chk("core_en_onehot", both_seen, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
